// File: rtl/reduce_pkg.sv
// Shared types and helpers for the frame reduction stream block.
package reduce_pkg;

  // Frame operator; op_sel encoding 2'b11 also maps to XOR.
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10
  } op_e;

  // IDLE: no frame open, ACCUM: frame open, HOLD: result pending.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_HOLD  = 2'b10
  } state_e;

  // Combine two bits with the frame operator.
  function automatic logic op_apply(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  // Map the raw op_sel field onto the operator enum.
  function automatic op_e op_decode(input logic [1:0] sel);
    op_e r;
    case (sel)
      2'b00:   r = OP_AND;
      2'b01:   r = OP_OR;
      default: r = OP_XOR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reduce_word.sv
// Single-word reduction: folds every bit of one word with the given operator.
module reduce_word
  import reduce_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  // Pure combinational bit fold.
  always_comb begin
    bit_o = 1'b0;
    case (op_i)
      OP_AND:  bit_o = &data_i;
      OP_OR:   bit_o = |data_i;
      default: bit_o = ^data_i;
    endcase
  end

endmodule

// File: rtl/reduce_stream.sv
// Frame reducer: folds every bit of every beat in a frame into one result bit,
// counts the beats (saturating) and holds the result until it is consumed.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high in IDLE/ACCUM and low in HOLD; out_valid is
// high only in HOLD and the outputs stay stable there until out_ready is seen.
module reduce_stream
  import reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output state_e           dbg_state
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  op_e  word_op;
  logic word_bit;
  logic accept;

  // The first beat of a frame uses op_sel directly; later beats use the latched operator.
  assign word_op = (state_q == S_IDLE) ? op_decode(op_sel) : op_q;

  reduce_word #(.WIDTH(WIDTH)) u_word (
    .op_i   (word_op),
    .data_i (in_data),
    .bit_o  (word_bit)
  );

  assign in_ready  = (state_q != S_HOLD);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_HOLD);
  assign out_bit   = out_valid ? acc_q : 1'b0;
  assign out_count = out_valid ? count_q : '0;
  assign out_sat   = out_valid ? sat_q : 1'b0;
  assign dbg_state = state_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op_decode(op_sel);
          acc_d   = word_bit;
          count_d = CNT_W'(1);
          sat_d   = 1'b0;
          state_d = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_d = op_apply(op_q, acc_q, word_bit);
          if (count_q == {CNT_W{1'b1}}) begin
            sat_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
          if (in_last) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = 1'b0;
          count_d = '0;
          sat_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state registers; synchronous reset discards any open frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_AND;
      acc_q   <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: doc/reduce_stream.md
REDUCE_STREAM -- requirements
Module: reduce_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the bit width of one input word (WIDTH >= 1).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the beat counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge clk.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port op_sel, input, 2 bits: reduction operator, 00=AND, 01=OR, 10=XOR, 11=XOR.
REQ-006 The block SHALL have port in_valid, input, 1 bit: an input word is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts an input word this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: the input word.
REQ-009 The block SHALL have port in_last, input, 1 bit: this word is the final beat of a frame.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port out_bit, output, 1 bit: the reduction of every bit of every word in the frame.
REQ-013 The block SHALL have port out_count, output, CNT_W bits: the number of beats in the frame.
REQ-014 The block SHALL have port out_sat, output, 1 bit: out_count saturated.

Function
REQ-015 An input beat SHALL be accepted when in_valid and in_ready are both high on a clock edge.
REQ-016 The FSM SHALL have three states: IDLE (no frame open), ACCUM (frame open), HOLD (result pending).
REQ-017 in_ready SHALL be high in IDLE and ACCUM, and low in HOLD.
REQ-018 In IDLE, a beat SHALL be accepted; op_sel is latched into the frame operator; acc = reduce(in_data); count = 1; the next state is ACCUM, or HOLD if in_last.
REQ-019 In ACCUM, each accepted beat SHALL update acc = acc OP reduce(in_data) using the latched operator; op_sel changes mid-frame are ignored.
REQ-020 An accepted beat with in_last SHALL move the FSM to HOLD; out_valid rises on the next cycle (1-cycle latency from the last beat).
REQ-021 In HOLD, out_valid SHALL be 1, and out_bit, out_count and out_sat are stable until the handshake.
REQ-022 out_valid and out_ready both high SHALL move the FSM to IDLE; no beat is accepted in that cycle.
REQ-023 count SHALL increment per accepted beat and saturate at 2^CNT_W-1; out_sat is set if any increment was blocked.
REQ-024 A single-beat frame SHALL give out_bit = reduce(in_data) and out_count = 1.
REQ-025 Cycles with in_valid low in ACCUM SHALL leave acc and count unchanged (bubbles allowed).
REQ-026 Outside HOLD, out_bit, out_count and out_sat SHALL be driven 0.

Reset
REQ-027 rst high on a clock edge SHALL force IDLE, acc=0, count=0, sat=0, out_valid=0 and in_ready=1 on the next cycle.
REQ-028 rst SHALL override any handshake in the same cycle; a frame in progress is discarded and produces no output.

Structure
REQ-029 Package reduce_pkg SHALL hold the enum op_e (OP_AND, OP_OR, OP_XOR), the FSM state enum state_e, and function op_apply(op, a, b).
REQ-030 Sub-module reduce_word SHALL be a parametrised combinational single-word reduction (WIDTH, op) producing one bit; reduce_stream instantiates it once.
REQ-031 The design SHALL use no latches; all state is in one always_ff block; next-state logic is in always_comb.

Verification
REQ-032 Test: WIDTH=8, XOR, beats 0x01, 0x03, 0x80 (last) -> out_bit=0, out_count=3, out_valid exactly 1 cycle after the last beat.
REQ-033 Test: AND, beats 0xFF, 0xFE (last) -> out_bit=0; then AND, single beat 0xFF (last) -> out_bit=1, out_count=1.
REQ-034 Test: OR frame 0x00, 0x00 (last), with out_ready held low 5 cycles -> out_valid and outputs stable, in_ready=0 throughout, out_bit=0.
REQ-035 Test: op_sel changes from XOR to AND mid-frame -> the result matches XOR.
REQ-036 Test: CNT_W=2, 5-beat frame -> out_count=3, out_sat=1.
REQ-037 Test: rst asserted in ACCUM after 2 beats -> no out_valid; the next frame 0x01 (last) under XOR -> out_bit=1, out_count=1.
